// File: rtl/stream_accel_pkg.sv
// Shared types and helpers for the line window buffer and its line memories.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package stream_accel_pkg;

  // Frame sequencing: wait for start, prime the line memories, then emit windows.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_e;

  localparam int unsigned DEF_LANES        = 8;
  localparam int unsigned DEF_DATA_W       = 8;
  localparam int unsigned DEF_KERNEL       = 3;
  localparam int unsigned DEF_ROW_BUF_SIZE = 256;

  typedef logic [DEF_DATA_W-1:0]           lane_t;
  typedef logic [DEF_LANES*DEF_DATA_W-1:0] beat_t;

  // Bit offset of (lane, row k) inside the flattened window bus; k=0 is the oldest row.
  function automatic int unsigned map_idx(input int unsigned lane, input int unsigned k,
                                          input int unsigned kernel, input int unsigned data_w);
    return (lane * kernel + k) * data_w;
  endfunction

endpackage

// File: rtl/line_mem.sv
// One image row of beats: synchronous write, asynchronous read at the same address.
// Latency: read is combinational; a write is visible from the next cycle.
// Backpressure: none; the owner gates writes with we_i.
//
// Ports:
//   clk_i   - clock
//   we_i    - write enable
//   addr_i  - shared read/write address (column index)
//   wdata_i - beat to store
//   rdata_o - beat currently stored at addr_i (pre-write value in the write cycle)
module line_mem #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  // No reset: contents are always overwritten before they are used as window data.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/line_window_buffer.sv
// Buffers KERNEL-1 image rows and emits a KERNEL-tall pixel column per lane for each input beat.
// Latency: 1 cycle from beat acceptance to valid window on mapping/valid.
// Backpressure: in_ready drops while a held window is not taken (out_ready=0) or route_en=0.
//
// Optional feature: define ZERO_PAD_EN to skip FILL and read not-yet-received rows as zero,
// so windows start on row 0 of the frame.
//
// Ports:
//   clk, nrst          - clock, async active-low reset
//   start              - frame active level; low returns to IDLE
//   route_en           - input gate
//   col_size           - beats per row, sampled when leaving IDLE
//   in_valid/in_ready  - input beat handshake, data_in carries LANES pixels
//   out_ready          - downstream ready for mapping
//   mapping            - per lane, KERNEL pixels, row 0 oldest
//   valid              - per-lane window valid (all lanes equal)
//   row_done           - 1-cycle pulse after the last beat of a row is accepted
module line_window_buffer
  import stream_accel_pkg::*;
#(
  parameter  int unsigned LANES        = DEF_LANES,
  parameter  int unsigned DATA_W       = DEF_DATA_W,
  parameter  int unsigned KERNEL       = DEF_KERNEL,
  parameter  int unsigned ROW_BUF_SIZE = DEF_ROW_BUF_SIZE,
  localparam int unsigned ADDR_W       = $clog2(ROW_BUF_SIZE)
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           start,
  input  logic                           route_en,
  input  logic [ADDR_W-1:0]              col_size,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*DATA_W-1:0]        data_in,
  input  logic                           out_ready,
  output logic [LANES*KERNEL*DATA_W-1:0] mapping,
  output logic [LANES-1:0]               valid,
  output logic                           row_done
);

  localparam int unsigned BEAT_W = LANES * DATA_W;
  localparam int unsigned MAP_W  = LANES * KERNEL * DATA_W;
  localparam int unsigned NROWS  = KERNEL - 1;
  localparam int unsigned RC_W   = $clog2(KERNEL + 1);
  localparam logic [RC_W-1:0] ROW_LAST = RC_W'(KERNEL - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] col_size_q;
  logic [ADDR_W-1:0] col_cnt_q,  col_cnt_d;
  logic [RC_W-1:0]   row_cnt_q,  row_cnt_d;
  logic              out_vld_q,  out_vld_d;
  logic              row_done_q, row_done_d;
  logic [MAP_W-1:0]  mapping_q,  mapping_d;

  logic              accept;
  logic              col_last;
  logic              load;
  logic [MAP_W-1:0]  window;
  logic [NROWS-1:0]  row_ok;
  logic [BEAT_W-1:0] rd_row [NROWS];
  logic [BEAT_W-1:0] wr_row [NROWS];

  assign in_ready = route_en & (state_q != IDLE) & (~out_vld_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign col_last = (col_cnt_q == col_size_q - ADDR_W'(1));
  // FILL always hands over to STREAM on the edge that completes row KERNEL-2,
  // so every window-completing beat is accepted in STREAM.
  assign load     = accept & (state_q == STREAM);

  // Row chain: rd_row[0] is the previous row, rd_row[NROWS-1] the oldest.
  // On accept every memory shifts its column down by one row.
  for (genvar j = 0; j < NROWS; j++) begin : g_row
    if (j == 0) begin : g_first
      assign wr_row[j] = data_in;
    end else begin : g_next
      assign wr_row[j] = rd_row[j-1];
    end

    line_mem #(
      .DEPTH  (ROW_BUF_SIZE),
      .WIDTH  (BEAT_W),
      .ADDR_W (ADDR_W)
    ) u_line_mem (
      .clk_i   (clk),
      .we_i    (accept),
      .addr_i  (col_cnt_q),
      .wdata_i (wr_row[j]),
      .rdata_o (rd_row[j])
    );
  end

`ifdef ZERO_PAD_EN
  // rd_row[j] holds real data only once more than j rows of this frame have arrived.
  for (genvar j = 0; j < NROWS; j++) begin : g_fill
    assign row_ok[j] = (RC_W'(j) < row_cnt_q);
  end
`else
  assign row_ok = '1;
`endif

  // Window assembly: k=KERNEL-1 is the incoming beat, k=0 the row KERNEL-1 rows above.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    for (genvar k = 0; k < KERNEL; k++) begin : g_k
      localparam int unsigned IDX = map_idx(i, k, KERNEL, DATA_W);
      if (k == KERNEL - 1) begin : g_cur
        assign window[IDX +: DATA_W] = data_in[i*DATA_W +: DATA_W];
      end else begin : g_old
        assign window[IDX +: DATA_W] = row_ok[KERNEL-2-k] ?
                                       rd_row[KERNEL-2-k][i*DATA_W +: DATA_W] : '0;
      end
    end
  end

  // Column/row position; row_cnt stops at KERNEL-1 since only "enough rows" matters.
  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (accept) begin
      if (col_last) begin
        col_cnt_d = '0;
        if (row_cnt_q != ROW_LAST) begin
          row_cnt_d = row_cnt_q + RC_W'(1);
        end
      end else begin
        col_cnt_d = col_cnt_q + ADDR_W'(1);
      end
    end
  end

  // Output stage: a new window replaces the held one even while it is being drained.
  always_comb begin
    mapping_d  = mapping_q;
    out_vld_d  = out_vld_q;
    row_done_d = accept & col_last;
    if (load) begin
      mapping_d = window;
      out_vld_d = 1'b1;
    end else if (out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      col_size_q <= '0;
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      row_done_q <= 1'b0;
      mapping_q  <= '0;
    end else if (!start) begin
      // Abort: line memories keep stale rows, the next frame's fill overwrites them.
      state_q    <= IDLE;
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      row_done_q <= 1'b0;
    end else begin
      mapping_q  <= mapping_d;
      out_vld_q  <= out_vld_d;
      row_done_q <= row_done_d;
      case (state_q)
        IDLE: begin
          if (col_size != '0) begin
            col_size_q <= col_size;
            col_cnt_q  <= '0;
            row_cnt_q  <= '0;
`ifdef ZERO_PAD_EN
            state_q    <= STREAM;
`else
            state_q    <= FILL;
`endif
          end
        end
        FILL: begin
          col_cnt_q <= col_cnt_d;
          row_cnt_q <= row_cnt_d;
          if (row_cnt_d == ROW_LAST) begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          col_cnt_q <= col_cnt_d;
          row_cnt_q <= row_cnt_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mapping  = mapping_q;
  assign valid    = {LANES{out_vld_q}};
  assign row_done = row_done_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer: table-driven beats plus hand sequences for
// backpressure, mid-frame abort, async reset and zero col_size.
// Latency/backpressure: expectations sampled 1 time unit after each active clock edge.
module tb_line_window_buffer;

  localparam int LANES  = 8;
  localparam int DATA_W = 8;
  localparam int KERNEL = 3;
  localparam int RBS    = 256;
  localparam int ADDR_W = 8;
  localparam int MAP_W  = LANES * KERNEL * DATA_W;

  logic                    clk = 1'b0;
  logic                    nrst;
  logic                    start;
  logic                    route_en;
  logic [ADDR_W-1:0]       col_size;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] data_in;
  logic                    out_ready;
  logic [MAP_W-1:0]        mapping;
  logic [LANES-1:0]        valid;
  logic                    row_done;

  int total = 0;
  int bad   = 0;

  // One input beat (lane i = base+i) and the outputs expected one cycle after it is accepted.
  // k2/k1/k0 are lane-0 values per window row; zmask marks rows expected to be zero.
  typedef struct {
    logic [7:0] base;
    logic       exp_vld;
    logic [7:0] k2;
    logic [7:0] k1;
    logic [7:0] k0;
    logic [2:0] zmask;
    logic       exp_done;
  } vec_t;

  always #5 clk = ~clk;

  line_window_buffer #(
    .LANES        (LANES),
    .DATA_W       (DATA_W),
    .KERNEL       (KERNEL),
    .ROW_BUF_SIZE (RBS)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .route_en  (route_en),
    .col_size  (col_size),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_ready (out_ready),
    .mapping   (mapping),
    .valid     (valid),
    .row_done  (row_done)
  );

  function automatic logic [LANES*DATA_W-1:0] beat(input logic [7:0] base);
    logic [LANES*DATA_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = base + 8'(i);
    return r;
  endfunction

  function automatic logic [MAP_W-1:0] exp_map(input vec_t v);
    logic [MAP_W-1:0] r;
    logic [7:0]       kv [3];
    kv[0] = v.k0;
    kv[1] = v.k1;
    kv[2] = v.k2;
    r = '0;
    for (int i = 0; i < LANES; i++)
      for (int k = 0; k < KERNEL; k++)
        r[(i*KERNEL+k)*DATA_W +: DATA_W] = v.zmask[k] ? 8'h00 : kv[k] + 8'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [MAP_W-1:0] act, input logic [MAP_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1: present the beat, confirm it is taken, check the registered result.
  task automatic apply(input vec_t v, input string tag);
    data_in  = beat(v.base);
    in_valid = 1'b1;
    #1;
    chk({tag, " in_ready"}, MAP_W'(in_ready), MAP_W'(1'b1));
    @(posedge clk);
    #1;
    chk({tag, " valid"}, MAP_W'(valid), MAP_W'({LANES{v.exp_vld}}));
    chk({tag, " row_done"}, MAP_W'(row_done), MAP_W'(v.exp_done));
    if (v.exp_vld) chk({tag, " mapping"}, mapping, exp_map(v));
  endtask

  vec_t t_fill [9];
  vec_t t_restart [6];
  vec_t t_pad [3];
  vec_t hold_v;

  initial begin
    // K=3, col_size=3: rows 0x00/0x10/0x20, beat b adds 8.
    t_fill[0] = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0};
    t_fill[1] = '{8'h08, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0};
    t_fill[2] = '{8'h10, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1};
    t_fill[3] = '{8'h10, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0};
    t_fill[4] = '{8'h18, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0};
    t_fill[5] = '{8'h20, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1};
    t_fill[6] = '{8'h20, 1'b1, 8'h20, 8'h10, 8'h00, 3'b000, 1'b0};
    t_fill[7] = '{8'h28, 1'b1, 8'h28, 8'h18, 8'h08, 3'b000, 1'b0};
    t_fill[8] = '{8'h30, 1'b1, 8'h30, 8'h20, 8'h10, 3'b000, 1'b1};
    // Restart with col_size=2: rows 0x80/0x90/0xA0.
    t_restart[0] = '{8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0};
    t_restart[1] = '{8'h88, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1};
    t_restart[2] = '{8'h90, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0};
    t_restart[3] = '{8'h98, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1};
    t_restart[4] = '{8'hA0, 1'b1, 8'hA0, 8'h90, 8'h80, 3'b000, 1'b0};
    t_restart[5] = '{8'hA8, 1'b1, 8'hA8, 8'h98, 8'h88, 3'b000, 1'b1};
    // Zero padding, col_size=1: every beat is a whole row.
    t_pad[0] = '{8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 3'b011, 1'b1};
    t_pad[1] = '{8'h10, 1'b1, 8'h10, 8'h00, 8'h00, 3'b001, 1'b1};
    t_pad[2] = '{8'h20, 1'b1, 8'h20, 8'h10, 8'h00, 3'b000, 1'b1};

    nrst      = 1'b1;
    start     = 1'b0;
    route_en  = 1'b0;
    col_size  = '0;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;

    // Reset values.
    #2 nrst = 1'b0;
    #1;
    chk("reset valid", MAP_W'(valid), '0);
    chk("reset mapping", mapping, '0);
    chk("reset in_ready", MAP_W'(in_ready), '0);
    chk("reset row_done", MAP_W'(row_done), '0);
    @(posedge clk);
    @(posedge clk);
    #1 nrst = 1'b1;

    route_en  = 1'b1;
    out_ready = 1'b1;
    start     = 1'b1;
`ifdef ZERO_PAD_EN
    col_size = 8'd1;
    #1;
    chk("idle in_ready", MAP_W'(in_ready), '0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) apply(t_pad[n], $sformatf("pad%0d", n));
`else
    col_size = 8'd3;
    #1;
    chk("idle in_ready", MAP_W'(in_ready), '0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 9; n++) apply(t_fill[n], $sformatf("fill%0d", n));

    // Backpressure: the row-3 beat waits while the previous window is held.
    hold_v    = t_fill[8];
    out_ready = 1'b0;
    data_in   = beat(8'h40);
    in_valid  = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk($sformatf("hold%0d in_ready", n), MAP_W'(in_ready), '0);
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d valid", n), MAP_W'(valid), MAP_W'({LANES{1'b1}}));
      chk($sformatf("hold%0d mapping", n), mapping, exp_map(hold_v));
    end
    out_ready = 1'b1;
    apply('{8'h40, 1'b1, 8'h40, 8'h20, 8'h10, 3'b000, 1'b0}, "bp0");
    apply('{8'h48, 1'b1, 8'h48, 8'h28, 8'h18, 3'b000, 1'b0}, "bp1");
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain valid", MAP_W'(valid), '0);

    // Abort mid-row, then a fresh frame with col_size=2.
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort valid", MAP_W'(valid), '0);
    chk("abort in_ready", MAP_W'(in_ready), '0);
    start    = 1'b1;
    col_size = 8'd2;
    @(posedge clk);
    #1;
    for (int n = 0; n < 6; n++) apply(t_restart[n], $sformatf("restart%0d", n));

    // Async reset mid-frame clears outputs without waiting for a clock edge.
    #2 nrst = 1'b0;
    #1;
    chk("arst valid", MAP_W'(valid), '0);
    chk("arst mapping", mapping, '0);
    chk("arst row_done", MAP_W'(row_done), '0);
    chk("arst in_ready", MAP_W'(in_ready), '0);

    // col_size=0 with start held: the block must stay idle.
    col_size = '0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 nrst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk($sformatf("zero_col%0d in_ready", n), MAP_W'(in_ready), '0);
      @(posedge clk);
      #1;
      chk($sformatf("zero_col%0d valid", n), MAP_W'(valid), '0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
